// File: rtl/instr_loader_if.sv
// Loader handshake and memory-write bundle.
// Slave side is the loader; master side drives the byte stream.
interface instr_loader_if #(
  parameter int ADDR_W = 7
) ();
  logic              start;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  modport slave (
    input  start, rx_data, rx_valid,
    output rx_ready, mem_we, mem_waddr,
    output mem_wdata, cpu_hold, busy,
    output done, error, words_loaded
  );

  modport master (
    output start, rx_data, rx_valid,
    input  rx_ready, mem_we, mem_waddr,
    input  mem_wdata, cpu_hold, busy,
    input  done, error, words_loaded
  );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: byte stream with 16-bit word count
// header, packed MSB first into instruction writes.
module instr_loader #(
  parameter int DEPTH  = 76,
  parameter int ADDR_W = 7
) (
  input logic           clk,
  input logic           reset,
  instr_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t            r_state, w_state;
  logic [15:0]       r_count, w_count;
  logic [31:0]       r_shift, w_shift;
  logic [1:0]        r_bcnt, w_bcnt;
  logic [15:0]       r_words, w_words;
  logic              r_we, w_we;
  logic [ADDR_W-1:0] r_waddr, w_waddr;
  logic [31:0]       r_wdata, w_wdata;
  logic              r_busy, w_busy;
  logic              r_done, w_done;
  logic              r_error, w_error;
  logic              r_hold, w_hold;
  logic              r_rdy, w_rdy;

  logic        w_xfer;
  logic [15:0] w_hdr;
  logic [31:0] w_word;
  logic [15:0] w_words_inc;

  assign w_xfer      = bus.rx_valid && r_rdy;
  assign w_hdr       = {r_count[15:8], bus.rx_data};
  assign w_word      = {r_shift[23:0], bus.rx_data};
  assign w_words_inc = r_words + 16'd1;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state;
  end

  // Next state and next registered outputs
  always_comb begin
    w_state = r_state;
    w_count = r_count;
    w_shift = r_shift;
    w_bcnt  = r_bcnt;
    w_words = r_words;
    w_we    = 1'b0;
    w_waddr = r_waddr;
    w_wdata = r_wdata;
    w_busy  = r_busy;
    w_done  = r_done;
    w_error = r_error;
    w_hold  = r_hold;
    unique case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (bus.start) begin
          w_state = S_LEN_HI;
          w_words = 16'd0;
          w_bcnt  = 2'd0;
          w_busy  = 1'b1;
          w_hold  = 1'b1;
          w_done  = 1'b0;
          w_error = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (w_xfer) begin
          w_count[15:8] = bus.rx_data;
          w_state       = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (w_xfer) begin
          w_count = w_hdr;
          if (w_hdr == 16'd0 ||
              w_hdr > 16'(DEPTH)) begin
            w_state = S_ERROR;
            w_busy  = 1'b0;
            w_error = 1'b1;
            w_hold  = 1'b1;
          end else begin
            w_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_xfer) begin
          w_shift = w_word;
          w_bcnt  = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_state = S_WRITE;
            w_we    = 1'b1;
            w_waddr = r_words[ADDR_W-1:0];
            w_wdata = w_word;
          end
        end
      end
      S_WRITE: begin
        w_words = w_words_inc;
        if (w_words_inc == r_count) begin
          w_state = S_DONE;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_hold  = 1'b0;
        end else begin
          w_state = S_DATA;
        end
      end
      default: w_state = S_IDLE;
    endcase
    w_rdy = (w_state == S_LEN_HI) ||
            (w_state == S_LEN_LO) ||
            (w_state == S_DATA);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_shift <= '0;
      r_bcnt  <= '0;
      r_words <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_hold  <= 1'b1;
      r_rdy   <= 1'b0;
    end else begin
      r_count <= w_count;
      r_shift <= w_shift;
      r_bcnt  <= w_bcnt;
      r_words <= w_words;
      r_we    <= w_we;
      r_waddr <= w_waddr;
      r_wdata <= w_wdata;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_error <= w_error;
      r_hold  <= w_hold;
      r_rdy   <= w_rdy;
    end
  end

  assign bus.rx_ready     = r_rdy;
  assign bus.mem_we       = r_we;
  assign bus.mem_waddr    = r_waddr;
  assign bus.mem_wdata    = r_wdata;
  assign bus.cpu_hold     = r_hold;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.error        = r_error;
  assign bus.words_loaded = r_words;

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: a stream model
// predicts writes, a monitor pops them on mem_we.
module tb_instr_loader;

  localparam int DEPTH  = 76;
  localparam int ADDR_W = 7;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   xfers;
  wr_t  exp_q[$];

  instr_loader_if #(.ADDR_W(ADDR_W)) ix ();

  instr_loader #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ix.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // Monitor: every write must match the model's next word
  always @(negedge clk) begin
    if (ix.mem_we === 1'b1) begin
      wr_t e;
      chk("wr_rx_ready", ix.rx_ready, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", ix.mem_waddr, e.addr);
        chk("wdata", ix.mem_wdata, e.data);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    ix.rx_valid = 1'b0;
    ix.start    = 1'b1;
    @(negedge clk);
    ix.start    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input bit stall);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (n > 100) begin
        chk("send_timeout", n, 0);
        return;
      end
      if (stall && $urandom_range(0, 1) == 0) begin
        ix.rx_valid = 1'b0;
        ix.rx_data  = 8'($urandom);
      end else begin
        ix.rx_valid = 1'b1;
        ix.rx_data  = b;
        if (ix.rx_ready) begin
          xfers++;
          return;
        end
      end
    end
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    ix.rx_valid = 1'b0;
    while (!(ix.done || ix.error) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("end_timeout", n, 0);
  endtask

  task automatic do_load(input bq_t q,
                         input bit stall,
                         input bit mid_start);
    logic [15:0] cnt;
    logic [31:0] w;
    bit          err;
    int          nb;
    cnt = {q[0], q[1]};
    err = (cnt == 0) || (cnt > DEPTH);
    if (!err) begin
      for (int i = 0; i < int'(cnt); i++) begin
        w = {q[2+4*i], q[3+4*i],
             q[4+4*i], q[5+4*i]};
        exp_q.push_back('{i, w});
      end
    end
    nb = err ? 2 : 2 + 4 * int'(cnt);
    xfers = 0;
    pulse_start();
    chk("hold_in_load", ix.cpu_hold, 1);
    chk("busy_in_load", ix.busy, 1);
    chk("done_cleared", ix.done, 0);
    for (int i = 0; i < nb; i++) begin
      send_byte(q[i], stall);
      if (mid_start && i == 5) begin
        pulse_start();
        chk("mid_start_busy", ix.busy, 1);
      end
    end
    wait_end();
    chk("end_done", ix.done, !err);
    chk("end_error", ix.error, err);
    chk("end_hold", ix.cpu_hold, err);
    chk("end_busy", ix.busy, 0);
    chk("end_words", ix.words_loaded,
        err ? 0 : cnt);
    chk("end_xfers", xfers, nb);
    chk("end_pending", exp_q.size(), 0);
  endtask

  task automatic idle_bytes(input logic [15:0] wl,
                            input bit dn);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ix.rx_valid = 1'b1;
      ix.rx_data  = 8'($urandom);
      chk("idle_ready", ix.rx_ready, 0);
      chk("idle_done", ix.done, dn);
      chk("idle_words", ix.words_loaded, wl);
    end
    @(negedge clk);
    ix.rx_valid = 1'b0;
  endtask

  initial begin
    bq_t q;
    checks      = 0;
    failures    = 0;
    xfers       = 0;
    reset       = 1'b1;
    ix.start    = 1'b0;
    ix.rx_valid = 1'b0;
    ix.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", ix.rx_ready, 0);
    chk("rst_we", ix.mem_we, 0);
    chk("rst_waddr", ix.mem_waddr, 0);
    chk("rst_wdata", ix.mem_wdata, 0);
    chk("rst_busy", ix.busy, 0);
    chk("rst_done", ix.done, 0);
    chk("rst_error", ix.error, 0);
    chk("rst_words", ix.words_loaded, 0);
    chk("rst_hold", ix.cpu_hold, 1);

    idle_bytes(16'd0, 1'b0);

    q = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE,
          8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    do_load(q, 1'b0, 1'b0);
    do_load(q, 1'b1, 1'b0);

    q = '{8'h00, 8'h00};
    do_load(q, 1'b0, 1'b0);
    q = '{8'h00, 8'h4D};
    do_load(q, 1'b1, 1'b0);

    q = '{8'h00, 8'h4C};
    for (int i = 0; i < 304; i++)
      q.push_back(8'($urandom));
    do_load(q, 1'b1, 1'b0);

    xfers = 0;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    @(negedge clk);
    ix.rx_valid = 1'b0;
    reset       = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_hold", ix.cpu_hold, 1);
    chk("mrst_busy", ix.busy, 0);
    chk("mrst_ready", ix.rx_ready, 0);
    chk("mrst_we", ix.mem_we, 0);
    chk("mrst_words", ix.words_loaded, 0);
    repeat (3) @(negedge clk);
    chk("mrst_idle_busy", ix.busy, 0);
    q = '{8'h00, 8'h01, 8'h11, 8'h22,
          8'h33, 8'h44};
    do_load(q, 1'b0, 1'b0);

    q = '{8'h00, 8'h03};
    for (int i = 0; i < 12; i++)
      q.push_back(8'($urandom));
    do_load(q, 1'b1, 1'b1);

    q = '{8'h00, 8'h01, 8'hCA, 8'hFE,
          8'hF0, 8'h0D};
    do_load(q, 1'b1, 1'b0);
    idle_bytes(16'd1, 1'b1);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
